e_mdu: RTL and testbench

- Parametrised multiply/divide unit for the E stage, the next step after the single-cycle E-stage ALU.
- Executes signed and unsigned multiply and divide over several cycles into private HI/LO registers.
- Serves move-from and move-to HI/LO, and exposes busy/stall status to the hazard unit.
- The pipeline forwards operands already selected. Results leave through rd_out in the E stage.

---
 rtl/e_mdu_pkg.sv | 32 +++
 rtl/e_mdu_if.sv | 28 ++
 rtl/e_mdu_core.sv | 71 +++++++
 rtl/e_mdu.sv | 120 ++++++++++++
 tb/tb_e_mdu.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/e_mdu_pkg.sv
// e_mdu shared package: mdu_sel encodings, FSM state type and helpers.
// Imported by the interface users, the core and the e_mdu top.
package e_mdu_pkg;

  localparam int MDU_SEL_W = 4;

  typedef enum logic [MDU_SEL_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_sel_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_st_e;

  function automatic logic is_mul_op(mdu_sel_e s);
    return (s == MDU_MULT) || (s == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(mdu_sel_e s);
    return (s == MDU_DIV) || (s == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: pipeline <-> MDU bundle (operands, op, start, status, results).
// master = E-stage/pipeline side, slave = e_mdu.
interface e_mdu_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] mdu_sel;
  logic             start;
  logic             busy;
  logic             stall_req;
  logic [WIDTH-1:0] rd_out;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output a, b, mdu_sel, start,
    input  busy, stall_req, rd_out, hi_out, lo_out
  );

  modport slave (
    input  a, b, mdu_sel, start,
    output busy, stall_req, rd_out, hi_out, lo_out
  );

endinterface

// File: rtl/e_mdu_core.sv
// e_mdu_core: combinational mult/multu/div/divu datapath.
// Ports: a_i, b_i, op_i -> hi_res_o, lo_res_o, div_zero_o.
module e_mdu_core
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  mdu_sel_e         op_i,
  output logic [WIDTH-1:0] hi_res_o,
  output logic [WIDTH-1:0] lo_res_o,
  output logic             div_zero_o
);

  localparam int PW = 2 * WIDTH;

  logic             sgn;
  logic             is_mul;
  logic             is_div;
  logic [PW-1:0]    ax;
  logic [PW-1:0]    bx;
  logic [PW-1:0]    prod;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  assign is_mul = is_mul_op(op_i);
  assign is_div = is_div_op(op_i);
  assign sgn    = (op_i == MDU_MULT) || (op_i == MDU_DIV);

  // Low 2W bits of the extended product are exact for both signednesses.
  assign ax   = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i}
                    : {{WIDTH{1'b0}}, a_i};
  assign bx   = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i}
                    : {{WIDTH{1'b0}}, b_i};
  assign prod = ax * bx;

  // Signed divide via magnitudes; min/-1 wraps back to min naturally.
  assign a_neg  = sgn & a_i[WIDTH-1];
  assign b_neg  = sgn & b_i[WIDTH-1];
  assign a_mag  = a_neg ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag  = b_neg ? (~b_i + WIDTH'(1)) : b_i;
  assign b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign q      = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
  assign r      = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;

  assign div_zero_o = is_div & (b_i == '0);

  always_comb begin
    hi_res_o = '0;
    lo_res_o = '0;
    unique case (1'b1)
      is_mul: {hi_res_o, lo_res_o} = prod;
      is_div: begin
        hi_res_o = r;
        lo_res_o = q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with private HI/LO for E stage.
// Ports: clk, reset (async high), bus (e_mdu_if.slave: a,b,mdu_sel,start -> busy,stall_req,rd_out,hi_out,lo_out).
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int SEL_W       = MDU_SEL_W
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave bus
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [SEL_W-1:0] sel_raw;
  mdu_sel_e         sel;
  logic             accept;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             core_dz;

  mdu_st_e          st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] sh_hi_q, sh_hi_d;
  logic [WIDTH-1:0] sh_lo_q, sh_lo_d;
  logic             sh_dz_q, sh_dz_d;

  assign sel_raw = bus.mdu_sel;
  assign sel     = mdu_sel_e'(sel_raw[MDU_SEL_W-1:0]);
  assign accept  = bus.start && (st_q == ST_IDLE)
                && (is_mul_op(sel) || is_div_op(sel));

  e_mdu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i       (bus.a),
    .b_i       (bus.b),
    .op_i      (sel),
    .hi_res_o  (core_hi),
    .lo_res_o  (core_lo),
    .div_zero_o(core_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_dz_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_dz_q <= sh_dz_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_dz_d = sh_dz_q;
    case (st_q)
      ST_IDLE: begin
        if (accept) begin
          sh_hi_d = core_hi;
          sh_lo_d = core_lo;
          sh_dz_d = core_dz;
          cnt_d   = is_mul_op(sel) ? CNT_W'(MULT_CYCLES - 1)
                                   : CNT_W'(DIV_CYCLES - 1);
          st_d    = ST_BUSY;
        end else if (sel == MDU_MTHI) begin
          hi_d = bus.a;
        end else if (sel == MDU_MTLO) begin
          lo_d = bus.a;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          // Divide by zero runs full length but leaves HI/LO alone.
          if (!sh_dz_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
          st_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign bus.busy      = (st_q == ST_BUSY);
  assign bus.stall_req = (st_q == ST_BUSY) | bus.start;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;

  always_comb begin
    bus.rd_out = '0;
    if (sel == MDU_MFHI) bus.rd_out = hi_q;
    else if (sel == MDU_MFLO) bus.rd_out = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed-vector bench for e_mdu.
// Drives and samples on the falling edge; results checked against hand values.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n;
  int   bad;

  always #5 clk = ~clk;

  e_mdu_if #(.WIDTH(32), .SEL_W(4)) bus ();

  e_mdu #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .SEL_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic drive(input mdu_sel_e s, input logic [31:0] a,
                       input logic [31:0] b, input logic st);
    bus.mdu_sel = s;
    bus.a       = a;
    bus.b       = b;
    bus.start   = st;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.mdu_sel = MDU_NONE;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.a       = '0;
    bus.b       = '0;
    bus.mdu_sel = MDU_NONE;
    bus.start   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_lo", bus.lo_out, 0);
    reset = 1'b0;
    @(negedge clk);

    drive(MDU_MTHI, 32'h55, 0, 0);
    chk("mthi", bus.hi_out, 32'h55);
    bus.mdu_sel = MDU_MFHI;
    #1 chk("mfhi", bus.rd_out, 32'h55);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_hi", bus.hi_out, 0);
    chk("arst_lo", bus.lo_out, 0);
    chk("arst_rd", bus.rd_out, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.mdu_sel = MDU_NONE;
    @(negedge clk);

    drive(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1);
    wait_idle(n);
    chk("mult_cyc", n, 5);
    chk("mult_hi", bus.hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo_out, 32'hFFFF_FFFA);

    drive(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1);
    wait_idle(n);
    chk("multu_cyc", n, 5);
    chk("multu_hi", bus.hi_out, 32'h2);
    chk("multu_lo", bus.lo_out, 32'hFFFF_FFFA);

    drive(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    wait_idle(n);
    chk("div_cyc", n, 10);
    chk("div_lo", bus.lo_out, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi_out, 32'hFFFF_FFFF);

    drive(MDU_DIVU, 32'd7, 32'd2, 1);
    wait_idle(n);
    chk("divu_lo", bus.lo_out, 32'd3);
    chk("divu_hi", bus.hi_out, 32'd1);

    drive(MDU_MTHI, 32'h1234_5678, 0, 0);
    drive(MDU_MTLO, 32'h1234_5678, 0, 0);
    drive(MDU_DIV, 32'd5, 32'd0, 1);
    wait_idle(n);
    chk("dz_cyc", n, 10);
    chk("dz_hi", bus.hi_out, 32'h1234_5678);
    chk("dz_lo", bus.lo_out, 32'h1234_5678);

    drive(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_idle(n);
    chk("ovf_lo", bus.lo_out, 32'h8000_0000);
    chk("ovf_hi", bus.hi_out, 32'h0);

    drive(MDU_MULT, 32'd4, 32'd5, 1);
    bad = 0;
    n   = 1;
    if (bus.stall_req !== 1'b1) bad++;
    drive(MDU_DIV, 32'd1, 32'd1, 1);
    while (bus.busy === 1'b1 && n < 64) begin
      if (bus.stall_req !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    chk("lock_cyc", n, 5);
    chk("lock_stall", bad, 0);
    chk("lock_hi", bus.hi_out, 32'h0);
    chk("lock_lo", bus.lo_out, 32'd20);

    drive(MDU_DIV, 32'd9, 32'd0, 1);
    drive(MDU_MTHI, 32'hAAAA, 0, 0);
    wait_idle(n);
    chk("busy_mthi_hi", bus.hi_out, 32'h0);
    chk("busy_mthi_lo", bus.lo_out, 32'd20);

    bus.start = 1'b1;
    #1 chk("stall_start", bus.stall_req, 1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("none_ignored", bus.busy, 0);

    drive(MDU_DIV, 32'd100, 32'd7, 1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_hi", bus.hi_out, 0);
    chk("mrst_lo", bus.lo_out, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mrst_nobusy", bus.busy, 0);
    chk("mrst_hi2", bus.hi_out, 0);
    chk("mrst_lo2", bus.lo_out, 0);

    drive(MDU_MTLO, 32'd5, 0, 0);
    bus.mdu_sel = MDU_MFLO;
    #1 chk("mflo", bus.rd_out, 32'd5);
    bus.mdu_sel = MDU_NONE;
    #1 chk("rd_none", bus.rd_out, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
